// File: rtl/mem_access_unit_pkg.sv
// Shared RV32I memory-stage definitions: opcodes, funct3 codes, FSM states,
// exception codes and instruction-class helpers.
package riscv_mem_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_TIMEOUT  = 2'd2
    } exc_t;

    // Non-memory opcodes that produce a register result.
    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_REG) || (op == OP_LUI) || (op == OP_AUIPC) ||
               (op == OP_JAL) || (op == OP_JALR) || (op == OP_SYSTEM);
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Sub-word lane steering: byte enables and store data replication, load byte/half
// extraction with sign/zero extension, and alignment checking.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be         = 4'b1111;
        wdata      = '0;
        load_data  = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:    misaligned = 1'b0;
            F3_H:    misaligned = addr_lo[0];
            F3_W:    misaligned = (addr_lo != 2'b00);
            F3_BU:   misaligned = store;
            F3_HU:   misaligned = store | addr_lo[0];
            default: misaligned = 1'b1;
        endcase
        if (store) begin
            case (funct3)
                F3_B: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{rs2[7:0]}};
                end
                F3_H: begin
                    be    = 4'b0011 << addr_lo;
                    wdata = {2{rs2[15:0]}};
                end
                default: wdata = rs2;
            endcase
        end
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked RV32I memory-access stage: one outstanding load/store on a
// req/gnt/rvalid bus, with misalignment and bus-timeout reporting.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned PASS_LAT0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_ir,
    input  logic [31:0]       in_alu_out,
    input  logic [31:0]       in_rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_ir,
    output logic [31:0]       out_alu_out,
    output logic [31:0]       out_load_data,
    output logic              out_rd_we,
    output logic [1:0]        out_exc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    localparam int unsigned    CNT_W   = 16;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, ir_reg, alu_reg, rs2_reg, load_data_reg;
    logic              rd_we_reg;
    exc_t              exc_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic        in_mem, in_rd_we, pass_now, accept, use_in, timeout_hit, reg_store;
    logic        al_store, al_mis;
    logic [2:0]  al_f3;
    logic [1:0]  al_addr;
    logic [31:0] al_rs2, al_wdata, al_load;
    logic [3:0]  al_be;

    assign in_mem   = (in_ir[6:0] == OP_LOAD) || (in_ir[6:0] == OP_STORE);
    assign in_rd_we = !in_mem && writes_rd(in_ir[6:0]) && (in_ir[11:7] != 5'd0);
    assign pass_now = (PASS_LAT0 != 0) && (state_reg == IDLE) && in_valid && !in_mem;
    assign reg_store = (ir_reg[6:0] == OP_STORE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TO_LAST);

    // The aligner sees the incoming bundle while accepting, the captured one otherwise.
    assign use_in   = (state_reg == IDLE) || (state_reg == RESP);
    assign al_store = use_in ? (in_ir[6:0] == OP_STORE) : reg_store;
    assign al_f3    = use_in ? in_ir[14:12] : ir_reg[14:12];
    assign al_addr  = use_in ? in_alu_out[1:0] : alu_reg[1:0];
    assign al_rs2   = use_in ? in_rs2_data : rs2_reg;

    lsu_align u_align (
        .store      (al_store),
        .funct3     (al_f3),
        .addr_lo    (al_addr),
        .rs2        (al_rs2),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    always_comb begin
        case (state_reg)
            IDLE:    in_ready = pass_now ? out_ready : 1'b1;
            RESP:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready && !pass_now;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (state_reg == RESP && out_ready) state_next = IDLE;
                if (accept) state_next = (in_mem && !al_mis) ? REQ : RESP;
            end
            REQ: begin
                if (dmem_gnt)         state_next = reg_store ? RESP : WAIT_R;
                else if (timeout_hit) state_next = RESP;
            end
            WAIT_R: begin
                if (dmem_rvalid || timeout_hit) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pc_reg        <= '0;
            ir_reg        <= '0;
            alu_reg       <= '0;
            rs2_reg       <= '0;
            load_data_reg <= '0;
            rd_we_reg     <= 1'b0;
            exc_reg       <= EXC_NONE;
            cnt_reg       <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + 1'b1;
            if (accept) begin
                pc_reg        <= in_pc;
                ir_reg        <= in_ir;
                alu_reg       <= in_alu_out;
                rs2_reg       <= in_rs2_data;
                load_data_reg <= '0;
                rd_we_reg     <= in_rd_we;
                exc_reg       <= (in_mem && al_mis) ? EXC_MISALIGN : EXC_NONE;
            end else if (state_reg == WAIT_R && dmem_rvalid) begin
                load_data_reg <= al_load;
                rd_we_reg     <= (ir_reg[11:7] != 5'd0);
            end else if ((state_reg == REQ && !dmem_gnt && timeout_hit) ||
                         (state_reg == WAIT_R && timeout_hit)) begin
                exc_reg       <= EXC_TIMEOUT;
                rd_we_reg     <= 1'b0;
                load_data_reg <= '0;
            end
        end
    end

    assign out_valid     = (state_reg == RESP) || pass_now;
    assign out_pc        = pass_now ? in_pc : pc_reg;
    assign out_ir        = pass_now ? in_ir : ir_reg;
    assign out_alu_out   = pass_now ? in_alu_out : alu_reg;
    assign out_load_data = pass_now ? '0 : load_data_reg;
    assign out_rd_we     = pass_now ? in_rd_we : rd_we_reg;
    assign out_exc       = pass_now ? EXC_NONE : exc_reg;

    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = dmem_req && reg_store;
    assign dmem_addr  = dmem_req ? {alu_reg[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? al_be : 4'b0000;
    assign dmem_wdata = dmem_req ? al_wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): stores, sub-word loads,
// misalignment, stalls/backpressure, bus timeout and reset mid-transaction.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_ir, in_alu_out, in_rs2_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_ir, out_alu_out, out_load_data;
    logic        out_rd_we;
    logic [1:0]  out_exc;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] IR_SB  = 32'h0000_0023;
    localparam logic [31:0] IR_SH  = 32'h0000_1023;
    localparam logic [31:0] IR_SW  = 32'h0000_2023;
    localparam logic [31:0] IR_LB  = 32'h0000_0283;
    localparam logic [31:0] IR_LW  = 32'h0000_2283;
    localparam logic [31:0] IR_LBU = 32'h0000_4283;
    localparam logic [31:0] IR_ADD = 32'h0000_01B3;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(4), .PASS_LAT0(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_alu_out(in_alu_out), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_alu_out(out_alu_out),
        .out_load_data(out_load_data), .out_rd_we(out_rd_we), .out_exc(out_exc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, ir, alu, rs2);
        in_valid = 1'b1; in_pc = pc; in_ir = ir; in_alu_out = alu; in_rs2_data = rs2;
    endtask

    // Load with immediate grant and rvalid one cycle later.
    task automatic run_load(input string tag, input logic [31:0] ir, addr, rdata, exp);
        drive(32'h80, ir, addr, 32'h0);
        tick();
        in_valid = 1'b0; dmem_gnt = 1'b1;
        #1 chk({tag, "_req"}, dmem_req, 1);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        #1 chk({tag, "_wait_noreq"}, dmem_req, 0);
        tick();
        dmem_rvalid = 1'b0;
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_load_data, exp);
        chk({tag, "_rdwe"}, out_rd_we, 1);
        $display("[TB] %s addr=%h rdata=%h load_data=%h", tag, addr, rdata, out_load_data);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_ir = '0; in_alu_out = '0; in_rs2_data = '0;
        out_ready = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_in_ready", in_ready, 1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        $display("[TB] reset checked");

        // SB to byte 3 with same-cycle grant
        drive(32'h10, IR_SB, 32'h103, 32'h0000_00AB);
        tick();
        in_valid = 1'b0; dmem_gnt = 1'b1;
        #1;
        chk("sb_req", dmem_req, 1);
        chk("sb_we", dmem_we, 1);
        chk("sb_addr", dmem_addr, 32'h100);
        chk("sb_be", dmem_be, 4'b1000);
        chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_not_valid_yet", out_valid, 0);
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("sb_valid", out_valid, 1);
        chk("sb_rdwe", out_rd_we, 0);
        chk("sb_exc", out_exc, 0);
        chk("sb_alu", out_alu_out, 32'h103);
        $display("[TB] SB addr=103 be=1000 wdata=ABABABAB");
        tick();
        chk("sb_done", out_valid, 0);

        // SH to upper half
        drive(32'h14, IR_SH, 32'h602, 32'h1234_BEEF);
        tick();
        in_valid = 1'b0; dmem_gnt = 1'b1;
        #1;
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_addr, 32'h600);
        $display("[TB] SH addr=602 be=%b wdata=%h", dmem_be, dmem_wdata);
        tick();
        dmem_gnt = 1'b0;
        tick();

        run_load("lb", IR_LB, 32'h202, 32'h0080_0000, 32'hFFFF_FF80);
        run_load("lbu", IR_LBU, 32'h202, 32'h0080_0000, 32'h0000_0080);

        // Misaligned LW: no bus cycle
        drive(32'h20, IR_LW, 32'h302, 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("mis_noreq", dmem_req, 0);
        chk("mis_valid", out_valid, 1);
        chk("mis_exc", out_exc, 1);
        chk("mis_rdwe", out_rd_we, 0);
        chk("mis_data", out_load_data, 0);
        $display("[TB] LW addr=302 exc=%0d", out_exc);
        tick();

        // LW with delayed grant, delayed rvalid and downstream backpressure
        drive(32'h24, IR_LW, 32'h300, 32'h0);
        tick();
        in_valid = 1'b1; in_ir = IR_ADD; in_alu_out = 32'h5555;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", dmem_req, 1);
            chk("stall_addr", dmem_addr, 32'h300);
            chk("stall_be", dmem_be, 4'b1111);
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        dmem_gnt = 1'b1;
        #1 chk("stall_req_gnt", dmem_req, 1);
        tick();
        dmem_gnt = 1'b0;
        #1 chk("stall_wait_in_ready", in_ready, 0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_load_data, 32'hDEAD_BEEF);
            chk("hold_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("hold_release_in_ready", in_ready, 1);
        chk("hold_pc", out_pc, 32'h24);
        $display("[TB] LW stalled addr=300 data=%h", out_load_data);
        tick();
        chk("hold_done", out_valid, 0);

        // SW with no grant: timeout after 4 request cycles
        drive(32'h28, IR_SW, 32'h400, 32'h1);
        tick();
        in_valid = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (dmem_req) nreq++;
            if (out_valid) break;
            tick();
        end
        chk("to_req_cycles", nreq, 4);
        chk("to_valid", out_valid, 1);
        chk("to_exc", out_exc, 2);
        chk("to_rdwe", out_rd_we, 0);
        chk("to_req_dropped", dmem_req, 0);
        $display("[TB] SW timeout req_cycles=%0d exc=%0d", nreq, out_exc);
        tick();

        // Reset while waiting for rvalid, then a stray rvalid
        drive(32'h2C, IR_LW, 32'h500, 32'h0);
        tick();
        in_valid = 1'b0; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_req", dmem_req, 0);
        chk("rst2_pc", out_pc, 0);
        chk("rst2_alu", out_alu_out, 0);
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        #1;
        chk("rst2_stray_valid", out_valid, 0);
        chk("rst2_stray_in_ready", in_ready, 1);
        drive(32'h30, IR_ADD, 32'h1234_5678, 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("add_valid", out_valid, 1);
        chk("add_alu", out_alu_out, 32'h1234_5678);
        chk("add_pc", out_pc, 32'h30);
        chk("add_rdwe", out_rd_we, 1);
        chk("add_data", out_load_data, 0);
        chk("add_noreq", dmem_req, 0);
        $display("[TB] ADD after reset alu=%h rd_we=%0d", out_alu_out, out_rd_we);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
